// File: rtl/imem_pkg.sv
// Shared types for the instruction-fetch responder.
// XLEN, word type and the idle value driven on resp_data.
package imem_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // Value shown on resp_data whenever no instruction is valid.
    localparam word_t NOP_INSN = '0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used as the responder's output queue.
// Ports: clk, reset (async, active-high), i_push/i_data, i_pop/o_data,
//        o_full, o_empty, o_count (entries held).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: word store, fixed-latency read pipe, output FIFO.
// Ports: clk/reset, req_* (fetch in), resp_* (instruction out), wr_* (preload).
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output word_t             resp_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  word_t             wr_data
);

    localparam int OW = $clog2(DEPTH + 1);

    word_t              r_mem [0:(1<<ADDR_W)-1];
    logic [LATENCY-1:0] r_pvld;
    word_t              r_pdata [LATENCY];
    logic [OW-1:0]      r_occ;

    logic               w_accept;
    logic               w_pop;
    logic               w_exit;
    logic               w_bypass;
    logic               w_push;
    logic               w_fifo_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full_unused;
    logic [OW-1:0]      w_fifo_count_unused;
    logic               w_unused_addr;
    word_t              w_fifo_data;
    logic [ADDR_W-1:0]  w_idx;

    // Byte offset and bits above the store size are ignored (wrap).
    assign w_idx         = req_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{req_addr[XLEN-1:ADDR_W+2], req_addr[1:0]};

    // Registered state only: no path from resp_ready.
    assign req_ready = !reset && (r_occ < OW'(DEPTH));
    assign w_accept  = req_valid && req_ready;

    // The pipe exit is shown directly while the FIFO is empty, so the
    // first word appears without an extra FIFO cycle.
    assign w_exit     = r_pvld[LATENCY-1];
    assign resp_valid = !w_fifo_empty || w_exit;
    assign resp_data  = !w_fifo_empty ? w_fifo_data :
                        (w_exit ? r_pdata[LATENCY-1] : NOP_INSN);
    assign w_pop      = resp_valid && resp_ready;

    // An exiting word consumed on the spot skips the FIFO; otherwise it is
    // queued behind older words. occ <= DEPTH guarantees FIFO room.
    assign w_bypass   = w_fifo_empty && w_exit && resp_ready;
    assign w_push     = w_exit && !w_bypass;
    assign w_fifo_pop = !w_fifo_empty && resp_ready;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (r_pdata[LATENCY-1]),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full_unused),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count_unused)
    );

    // Store: read-first, a same-edge write is seen by the next fetch only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Data half of the latency pipe; qualified by r_pvld.
    always_ff @(posedge clk) begin
        r_pdata[0] <= r_mem[w_idx];
        for (int i = 1; i < LATENCY; i++) begin
            r_pdata[i] <= r_pdata[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pvld <= '0;
        end else begin
            r_pvld[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_pvld[i] <= r_pvld[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: vector table plus directed multi-cycle sequences.
// A queue of expected words with ready-cycle stamps checks every cycle.
module tb_imem_responder;

    import imem_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              resp_valid;
    logic              resp_ready;
    word_t             resp_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    word_t             wr_data;

    always #5 clk = ~clk;

    imem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc_n    = 0;
    int    n_acc    = 0;
    word_t q_data [$];
    int    q_stamp [$];
    word_t mdl [0:(1<<ADDR_W)-1];
    vec_t  tbl [19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance.
    task automatic cyc(input logic rv, input logic [31:0] a,
                       input logic [31:0] ex, input logic rr);
        logic exp_r;
        logic exp_v;
        req_valid  = rv;
        req_addr   = a;
        resp_ready = rr;
        #1;
        exp_r = !reset && (q_data.size() < DEPTH);
        exp_v = (q_data.size() > 0) && (cyc_n >= q_stamp[0]);
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_r});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_v});
        if (exp_v) begin
            chk("resp_data", resp_data, q_data[0]);
        end
        if (exp_v && rr) begin
            void'(q_data.pop_front());
            void'(q_stamp.pop_front());
        end
        if (rv && exp_r) begin
            q_data.push_back(ex);
            q_stamp.push_back(cyc_n + LATENCY);
            n_acc++;
        end
        @(posedge clk);
        cyc_n++;
        #1;
        wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (q_data.size() == 0) break;
            cyc(1'b0, 32'h0, 32'h0, 1'b1);
        end
        chk("drain_empty", q_data.size(), 0);
    endtask

    initial begin
        int a0;
        int idx;
        logic [31:0] a;

        for (int i = 0; i < 16; i++) begin
            tbl[i].addr = 32'(i * 4);
            tbl[i].exp  = 32'h1000 + 32'(i);
        end
        tbl[16].addr = 32'h0000_1004; tbl[16].exp = 32'h0000_1001;
        tbl[17].addr = 32'h0000_003F; tbl[17].exp = 32'h0000_100F;
        tbl[18].addr = 32'hFFFF_F008; tbl[18].exp = 32'h0000_1002;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        // Preload under reset; the store is not affected by reset.
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = 32'h1000 + 32'(i);
            mdl[i]  = 32'h1000 + 32'(i);
            cyc(1'b0, 32'h0, 32'h0, 1'b0);
        end
        chk("resp_data_rst", resp_data, NOP_INSN);
        reset = 1'b0;
        cyc(1'b0, 32'h0, 32'h0, 1'b1);

        // Streaming table with resp_ready high: one accept every cycle.
        a0 = n_acc;
        for (int i = 0; i < 19; i++) begin
            cyc(1'b1, tbl[i].addr, tbl[i].exp, 1'b1);
        end
        chk("stream_accepts", n_acc - a0, 19);
        drain();

        // Single fetch: word appears after edge E+LATENCY-1.
        cyc(1'b1, 32'h8, 32'h1002, 1'b1);
        chk("lat_early", {31'b0, resp_valid}, 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("lat_valid", {31'b0, resp_valid}, 32'h1);
        chk("lat_data", resp_data, 32'h1002);
        drain();

        // Backpressure: exactly DEPTH accepts, then release.
        a0 = n_acc;
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, 32'(k * 4), mdl[k], 1'b0);
        end
        chk("bp_accepts", n_acc - a0, DEPTH);
        chk("bp_hold_data", resp_data, 32'h1000);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("bp_ready_back", {31'b0, req_ready}, 32'h1);
        drain();

        // Random handshakes against the model.
        for (int k = 0; k < 1000; k++) begin
            idx = $urandom_range(0, 15);
            a   = {$urandom(), 2'b00};
            a[11:2] = 10'(idx);
            a[1:0]  = 2'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 3) != 0), a, mdl[idx],
                1'($urandom_range(0, 1)));
        end
        drain();

        // Read-first on a same-edge write.
        wr_en   = 1'b1;
        wr_addr = 10'd5;
        wr_data = 32'hDEAD_BEEF;
        cyc(1'b1, 32'h14, 32'h1005, 1'b1);
        mdl[5] = 32'hDEAD_BEEF;
        cyc(1'b1, 32'h14, 32'hDEAD_BEEF, 1'b1);
        drain();

        // Reset mid-flight with three outstanding.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'(k * 4), mdl[k], 1'b0);
        end
        chk("pre_rst_valid", {31'b0, resp_valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_async_ready", {31'b0, req_ready}, 32'h0);
        q_data.delete();
        q_stamp.delete();
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 32'(k * 4), mdl[k], 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
